// File: rtl/mem_arbiter_pkg.sv
// Shared types for the single-port memory arbiter.
// Optional round-robin arbitration is enabled with MEM_ARB_RR_EN.
package mem_arbiter_pkg;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_fence;
    logic        mem_spec;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        valid;
    logic        fence;
    logic        spec;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_arb_slot_type;

  typedef struct packed {
    arb_state_t state;
    logic       kill;
`ifdef MEM_ARB_RR_EN
    logic       last;
`endif
  } mem_arb_reg_type;

  localparam mem_arb_reg_type init_mem_arb_reg = '0;

  function automatic mem_arb_slot_type to_slot(
    input mem_in_type r
  );
    mem_arb_slot_type s;
    s.valid = r.mem_valid;
    s.fence = r.mem_fence;
    s.spec  = r.mem_spec;
    s.instr = r.mem_instr;
    s.addr  = r.mem_addr;
    s.wdata = r.mem_wdata;
    s.wstrb = r.mem_wstrb;
    return s;
  endfunction

  function automatic mem_in_type from_slot(
    input mem_arb_slot_type s
  );
    mem_in_type r;
    r.mem_valid = s.valid;
    r.mem_fence = s.fence;
    r.mem_spec  = s.spec;
    r.mem_instr = s.instr;
    r.mem_addr  = s.addr;
    r.mem_wdata = s.wdata;
    r.mem_wstrb = s.wstrb;
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the shared memory port.
// The arbiter takes the slave side; the environment drives the master side.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  mem_in_type  imem_in;
  mem_out_type imem_out;
  mem_in_type  dmem_in;
  mem_out_type dmem_out;
  mem_in_type  mem_in;
  mem_out_type mem_out;

  modport slave (
    input  imem_in,
    input  dmem_in,
    input  mem_out,
    output imem_out,
    output dmem_out,
    output mem_in
  );

  modport master (
    output imem_in,
    output dmem_in,
    output mem_out,
    input  imem_out,
    input  dmem_out,
    input  mem_in
  );

endinterface

// File: rtl/mem_arbiter_slot.sv
// Per-requester hold slot: latches an ungranted request,
// clears on grant, and offers the live request ahead of the held one.
module mem_arb_slot
  import mem_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  mem_in_type req_i,
  input  logic       grant_i,
  output mem_in_type cand_o
);

  mem_arb_slot_type slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (req_i.mem_valid && !grant_i) begin
      slot_d = to_slot(req_i);
    end else if (grant_i) begin
      slot_d = '0;
    end
  end

  always_comb begin
    cand_o = from_slot(slot_q);
    if (req_i.mem_valid) begin
      cand_o = req_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory bus between fetch and load/store requesters.
// Define MEM_ARB_RR_EN for round-robin instead of data-first priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic          reset,
  input  logic          clock,
  mem_arbiter_if.slave  bus
);

  mem_arb_reg_type r_q, r_d;
  mem_in_type      i_cand, d_cand;
  logic            i_gnt, d_gnt;
  logic            busy, rdy, can;

  mem_arb_slot u_islot (
    .clock   (clock),
    .reset   (reset),
    .req_i   (bus.imem_in),
    .grant_i (i_gnt),
    .cand_o  (i_cand)
  );

  mem_arb_slot u_dslot (
    .clock   (clock),
    .reset   (reset),
    .req_i   (bus.dmem_in),
    .grant_i (d_gnt),
    .cand_o  (d_cand)
  );

  always_comb begin
    r_d          = r_q;
    i_gnt        = 1'b0;
    d_gnt        = 1'b0;
    bus.mem_in   = '0;
    bus.imem_out = '0;
    bus.dmem_out = '0;
    busy = (r_q.state != ST_IDLE);
    rdy  = busy & bus.mem_out.mem_ready;
    can  = ~busy | rdy;

    if (!reset) begin
      if (can) begin
`ifdef MEM_ARB_RR_EN
        if (d_cand.mem_valid && i_cand.mem_valid) begin
          d_gnt = ~r_q.last;
          i_gnt = r_q.last;
        end else begin
          d_gnt = d_cand.mem_valid;
          i_gnt = i_cand.mem_valid;
        end
`else
        d_gnt = d_cand.mem_valid;
        i_gnt = i_cand.mem_valid & ~d_cand.mem_valid;
`endif
      end

      if (d_gnt) begin
        bus.mem_in = d_cand;
        r_d.state  = ST_BUSY_D;
      end else if (i_gnt) begin
        bus.mem_in = i_cand;
        r_d.state  = ST_BUSY_I;
      end else if (rdy) begin
        r_d.state  = ST_IDLE;
      end

`ifdef MEM_ARB_RR_EN
      if (d_gnt) r_d.last = 1'b1;
      if (i_gnt) r_d.last = 1'b0;
`endif

      bus.imem_out.mem_rdata = bus.mem_out.mem_rdata;
      bus.dmem_out.mem_rdata = bus.mem_out.mem_rdata;
      unique case (r_q.state)
        ST_BUSY_D: begin
          bus.dmem_out.mem_ready = bus.mem_out.mem_ready;
        end
        ST_BUSY_I: begin
          bus.imem_out.mem_ready =
            bus.mem_out.mem_ready & ~r_q.kill;
        end
        default: ;
      endcase

      // A redirect while a fetch is in flight makes its reply stale
      if (r_q.state == ST_BUSY_I) begin
        if (bus.mem_out.mem_ready) begin
          r_d.kill = 1'b0;
        end else if (bus.imem_in.mem_valid &&
                     bus.imem_in.mem_spec) begin
          r_d.kill = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_q <= init_mem_arb_reg;
    end else begin
      r_q <= r_d;
    end
  end

endmodule
